branch_ctrl: RTL and testbench
==============================

# branch_ctrl

Sequencer between fetch, execute and the 2-bit branch predictor. Tracks every in-flight conditional branch in a small in-order queue, along with its predicted direction and target. When a branch resolves, it drives the predictor's write port and detects mispredictions. On a mispredict it issues a one-cycle flush with the corrected PC. It sits beside IF/EX and owns the predictor's `we_i`/`waddr_i`/`res_taken` inputs.

## Interface
- `DEPTH`, 4, queue entries; power of two, ≥2
- `ADDR_W`, 32, PC width
- `clk` in 1: the block's single clock
- `rst` in 1: synchronous, active-high reset
- `rdy` in 1: global ready; when low, the block holds all state
- `br_fetch_i` in 1: IF pushes a conditional branch this cycle
- `br_pc_i` in ADDR_W: PC of the pushed branch
- `pred_taken_i` in 1: predictor's direction for `br_pc_i`
- `pred_target_i` in ADDR_W: target IF used if predicted taken
- `full_o` out 1: queue full; IF must stall branch fetch (combinational from count)
- `res_valid_i` in 1: EX resolves the oldest branch
- `res_taken_i` in 1: actual direction
- `res_target_i` in ADDR_W: actual taken target
- `ext_flush_i` in 1: external pipeline flush (e.g. jalr); clears queue
- `pred_we_o` out 1: predictor write enable
- `pred_waddr_o` out ADDR_W: predictor write PC
- `pred_res_taken_o` out 1: predictor update direction
- `flush_o` out 1: mispredict flush pulse
- `redirect_pc_o` out ADDR_W: correct next PC, valid with `flush_o`
- `count_o` out clog2(DEPTH)+1: current occupancy
- `mispred_cnt_o` out 16: saturating mispredict counter

## Operation
- **Queue:** circular FIFO of {pc, pred_taken, pred_target}. Read/write pointers wrap modulo DEPTH; `count_o` ranges 0..DEPTH.
- **Push:** accepted when `br_fetch_i && !full_o`. A push while full is dropped; the queue is unchanged.
- **Pop:** accepted when `res_valid_i && count_o != 0`. `res_valid_i` on an empty queue is ignored: no update, no flush.
- **Simultaneous push and pop** when not full: both occur and count is unchanged. When full, a push in the same cycle as a pop is still dropped, because `full_o` comes from the pre-edge count.
- **Predictor update:** on each pop, next cycle `pred_we_o`=1, `pred_waddr_o`=head pc, `pred_res_taken_o`=`res_taken_i`.
- **Mispredict:** true when head.pred_taken != `res_taken_i`, or when `res_taken_i` && head.pred_target != `res_target_i`.
- **On mispredict (pop cycle):**
  - next cycle `flush_o`=1 and `redirect_pc_o` = `res_taken_i` ? `res_target_i` : head pc + 4 (ADDR_W wrap).
  - Queue cleared (pointers=0, count=0) at the same edge; the same-cycle push is discarded as wrong-path.
  - `mispred_cnt_o` += 1, saturating at 0xFFFF.
- **Correct prediction:** head removed; no flush.
- **`ext_flush_i`:** clears the queue at the edge and drops any same-cycle push. A same-cycle pop still performs its predictor update and mispredict evaluation, because the oldest branch is architecturally resolved. `flush_o` is raised only for a mispredict, never for `ext_flush_i` alone.
- **`rdy`=0:** no pointer, count, counter or output register changes; all inputs ignored.

## Timing
- **Reset:** all of the following hold after the first rising edge with `rst`=1, regardless of `rdy`:
  - `pred_we_o`=0, `pred_waddr_o`=0, `pred_res_taken_o`=0
  - `flush_o`=0, `redirect_pc_o`=0
  - `count_o`=0, `full_o`=0, `mispred_cnt_o`=0
  - pointers=0
- **Reset mid-operation** discards all entries and suppresses any pending pulse.
- **Registered outputs:** all except `full_o`/`count_o` (which follow registered count) have 1-cycle latency from the resolving edge.
- **Pulse width:** `pred_we_o` and `flush_o` are single-cycle pulses. Both are 0 in any cycle not following an accepted pop.
- **Back-to-back pops** produce back-to-back `pred_we_o` pulses; after a mispredict flush the queue is empty, so the next pop needs a fresh push.
- **Registered-output values:** `pred_waddr_o`/`redirect_pc_o` hold their last value when their pulse is low.
- **Push-to-pop:** an entry pushed at edge N may be popped at edge N+1 or later.

## Test plan
- Reset, then push pc=0x100/pred_taken=0, resolve not-taken → next cycle `pred_we_o`=1, `pred_waddr_o`=0x100, `pred_res_taken_o`=0, `flush_o`=0, `count_o`=0.
- Push pc=0x200 with pred_taken=0, resolve taken with target=0x300 → `flush_o`=1, `redirect_pc_o`=0x300, `mispred_cnt_o`=1.
- Push pc=0x400 with pred_taken=1/target 0x480, resolve not-taken → `flush_o`=1, `redirect_pc_o`=0x404.
- Target mismatch: push pc=0x400 with pred_taken=1/target 0x480, resolve taken with target 0x500 → `flush_o`=1, `redirect_pc_o`=0x500.
- Push 4 entries (DEPTH=4) → `full_o`=1.
  - Fifth push dropped.
  - Resolve all 4 correctly → 4 consecutive `pred_we_o` pulses in FIFO PC order; `count_o` returns to 0.
  - `res_valid_i` on the empty queue → no pulse.
- Queue holding 2 entries, mispredict on head with simultaneous push → `count_o`=0 after the edge; push lost.
- Hold `rdy`=0 across a `res_valid_i` → no update.
- Assert `rst` mid-stream → all outputs 0 next cycle.
- Force 65536+ mispredicts → `mispred_cnt_o` stays 0xFFFF.

Source files
------------

// File: rtl/branch_ctrl.sv
// branch_ctrl: in-order queue of in-flight conditional branches. On
// resolution of the oldest branch it drives the predictor write port and,
// on a mispredict, issues a one-cycle flush with the corrected PC.
module branch_ctrl #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned MCNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        br_fetch_i,
  input  logic [ADDR_W-1:0]           br_pc_i,
  input  logic                        pred_taken_i,
  input  logic [ADDR_W-1:0]           pred_target_i,
  output logic                        full_o,
  input  logic                        res_valid_i,
  input  logic                        res_taken_i,
  input  logic [ADDR_W-1:0]           res_target_i,
  input  logic                        ext_flush_i,
  output logic                        pred_we_o,
  output logic [ADDR_W-1:0]           pred_waddr_o,
  output logic                        pred_res_taken_o,
  output logic                        flush_o,
  output logic [ADDR_W-1:0]           redirect_pc_o,
  output logic [$clog2(DEPTH):0]      count_o,
  output logic [MCNT_W-1:0]           mispred_cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              taken;
    logic [ADDR_W-1:0] target;
  } br_entry_t;

  br_entry_t          r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_pred_we;
  logic [ADDR_W-1:0]  r_pred_waddr;
  logic               r_pred_res_taken;
  logic               r_flush;
  logic [ADDR_W-1:0]  r_redirect_pc;
  logic [MCNT_W-1:0]  r_mispred_cnt;

  br_entry_t          w_head;
  br_entry_t          w_new;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_mispred;
  logic               w_clear;
  logic [ADDR_W-1:0]  w_redirect;

  // Queue status, accept conditions and mispredict detection on the head entry
  always_comb begin
    w_head     = r_mem[r_rd_ptr];
    w_new      = '{pc: br_pc_i, taken: pred_taken_i, target: pred_target_i};
    w_full     = (r_count == CNT_W'(DEPTH));
    w_push     = br_fetch_i && !w_full;
    w_pop      = res_valid_i && (r_count != '0);
    w_mispred  = w_pop && ((w_head.taken != res_taken_i) ||
                           (res_taken_i && (w_head.target != res_target_i)));
    w_clear    = ext_flush_i || w_mispred;
    w_redirect = res_taken_i ? res_target_i : (w_head.pc + ADDR_W'(4));
  end

  // Entry storage; wrong-path pushes (same cycle as a clear) are not written
  always_ff @(posedge clk) begin
    if (!rst && rdy && w_push && !w_clear) begin
      r_mem[r_wr_ptr] <= w_new;
    end
  end

  // Pointers, occupancy, predictor-update / flush pulses and mispredict counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_count          <= '0;
      r_pred_we        <= 1'b0;
      r_pred_waddr     <= '0;
      r_pred_res_taken <= 1'b0;
      r_flush          <= 1'b0;
      r_redirect_pc    <= '0;
      r_mispred_cnt    <= '0;
    end else if (rdy) begin
      r_pred_we <= w_pop;
      r_flush   <= w_mispred;
      if (w_pop) begin
        r_pred_waddr     <= w_head.pc;
        r_pred_res_taken <= res_taken_i;
      end
      if (w_mispred) begin
        r_redirect_pc <= w_redirect;
        if (r_mispred_cnt != '1) begin
          r_mispred_cnt <= r_mispred_cnt + MCNT_W'(1);
        end
      end
      if (w_clear) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
          r_count <= r_count - CNT_W'(1);
        end
      end
    end
  end

  assign full_o           = w_full;
  assign count_o          = r_count;
  assign pred_we_o        = r_pred_we;
  assign pred_waddr_o     = r_pred_waddr;
  assign pred_res_taken_o = r_pred_res_taken;
  assign flush_o          = r_flush;
  assign redirect_pc_o    = r_redirect_pc;
  assign mispred_cnt_o    = r_mispred_cnt;

endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: table-driven checks of branch_ctrl plus a mispredict
// counter saturation sequence on a narrow-counter instance.
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, fetch, pt, rv, rt, xf;
  logic [31:0] pc, ptgt, rtgt;

  logic        full, we, rtk, fl;
  logic [31:0] wa, rd;
  logic [2:0]  cnt;
  logic [15:0] mc;

  logic        s_full, s_we, s_rtk, s_fl;
  logic [31:0] s_wa, s_rd;
  logic [2:0]  s_cnt;
  logic [3:0]  s_mc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_ctrl u_dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .br_fetch_i(fetch), .br_pc_i(pc), .pred_taken_i(pt), .pred_target_i(ptgt),
    .full_o(full),
    .res_valid_i(rv), .res_taken_i(rt), .res_target_i(rtgt), .ext_flush_i(xf),
    .pred_we_o(we), .pred_waddr_o(wa), .pred_res_taken_o(rtk),
    .flush_o(fl), .redirect_pc_o(rd), .count_o(cnt), .mispred_cnt_o(mc)
  );

  branch_ctrl #(.MCNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .rdy(rdy),
    .br_fetch_i(fetch), .br_pc_i(pc), .pred_taken_i(pt), .pred_target_i(ptgt),
    .full_o(s_full),
    .res_valid_i(rv), .res_taken_i(rt), .res_target_i(rtgt), .ext_flush_i(xf),
    .pred_we_o(s_we), .pred_waddr_o(s_wa), .pred_res_taken_o(s_rtk),
    .flush_o(s_fl), .redirect_pc_o(s_rd), .count_o(s_cnt), .mispred_cnt_o(s_mc)
  );

  typedef struct {
    logic        rst, rdy, fetch;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptgt;
    logic        rv, rt;
    logic [31:0] rtgt;
    logic        xf;
    logic        we;
    logic [31:0] wa;
    logic        ert, fl;
    logic [31:0] rd;
    logic [2:0]  cnt;
    logic        full;
    logic [15:0] mc;
  } vec_t;

  function automatic vec_t mk(
    input logic a_rst, input logic a_rdy, input logic a_fe, input logic [31:0] a_pc,
    input logic a_pt, input logic [31:0] a_ptgt, input logic a_rv, input logic a_rt,
    input logic [31:0] a_rtgt, input logic a_xf,
    input logic e_we, input logic [31:0] e_wa, input logic e_rt, input logic e_fl,
    input logic [31:0] e_rd, input logic [2:0] e_cnt, input logic e_full,
    input logic [15:0] e_mc);
    vec_t v;
    v.rst = a_rst; v.rdy = a_rdy; v.fetch = a_fe; v.pc = a_pc; v.pt = a_pt;
    v.ptgt = a_ptgt; v.rv = a_rv; v.rt = a_rt; v.rtgt = a_rtgt; v.xf = a_xf;
    v.we = e_we; v.wa = e_wa; v.ert = e_rt; v.fl = e_fl; v.rd = e_rd;
    v.cnt = e_cnt; v.full = e_full; v.mc = e_mc;
    return v;
  endfunction

  task automatic drive(input logic a_rst, input logic a_rdy, input logic a_fe,
                       input logic [31:0] a_pc, input logic a_pt, input logic [31:0] a_ptgt,
                       input logic a_rv, input logic a_rt, input logic [31:0] a_rtgt,
                       input logic a_xf);
    rst = a_rst; rdy = a_rdy; fetch = a_fe; pc = a_pc; pt = a_pt; ptgt = a_ptgt;
    rv = a_rv; rt = a_rt; rtgt = a_rtgt; xf = a_xf;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  vec_t vecs [34];

  initial begin
    //            rst rdy fe pc      pt ptgt     rv rt rtgt     xf | we wa      rt fl rd      cnt full mc
    vecs[0]  = mk(1, 1, 0, 0,       0, 0,       0, 0, 0,       0,   0, 0,      0, 0, 0,      0, 0, 0);
    vecs[1]  = mk(0, 1, 1, 'h100,   0, 0,       0, 0, 0,       0,   0, 0,      0, 0, 0,      1, 0, 0);
    vecs[2]  = mk(0, 1, 0, 0,       0, 0,       1, 0, 0,       0,   1, 'h100,  0, 0, 0,      0, 0, 0);
    vecs[3]  = mk(0, 1, 0, 0,       0, 0,       0, 0, 0,       0,   0, 'h100,  0, 0, 0,      0, 0, 0);
    vecs[4]  = mk(0, 1, 1, 'h200,   0, 0,       0, 0, 0,       0,   0, 'h100,  0, 0, 0,      1, 0, 0);
    vecs[5]  = mk(0, 1, 0, 0,       0, 0,       1, 1, 'h300,   0,   1, 'h200,  1, 1, 'h300,  0, 0, 1);
    vecs[6]  = mk(0, 1, 1, 'h400,   1, 'h480,   0, 0, 0,       0,   0, 'h200,  1, 0, 'h300,  1, 0, 1);
    vecs[7]  = mk(0, 1, 0, 0,       0, 0,       1, 0, 0,       0,   1, 'h400,  0, 1, 'h404,  0, 0, 2);
    vecs[8]  = mk(0, 1, 1, 'h400,   1, 'h480,   0, 0, 0,       0,   0, 'h400,  0, 0, 'h404,  1, 0, 2);
    vecs[9]  = mk(0, 1, 0, 0,       0, 0,       1, 1, 'h500,   0,   1, 'h400,  1, 1, 'h500,  0, 0, 3);
    vecs[10] = mk(0, 1, 1, 'h10,    1, 'h1010,  0, 0, 0,       0,   0, 'h400,  1, 0, 'h500,  1, 0, 3);
    vecs[11] = mk(0, 1, 1, 'h20,    1, 'h1020,  0, 0, 0,       0,   0, 'h400,  1, 0, 'h500,  2, 0, 3);
    vecs[12] = mk(0, 1, 1, 'h30,    1, 'h1030,  0, 0, 0,       0,   0, 'h400,  1, 0, 'h500,  3, 0, 3);
    vecs[13] = mk(0, 1, 1, 'h40,    1, 'h1040,  0, 0, 0,       0,   0, 'h400,  1, 0, 'h500,  4, 1, 3);
    vecs[14] = mk(0, 1, 1, 'h50,    1, 'h1050,  0, 0, 0,       0,   0, 'h400,  1, 0, 'h500,  4, 1, 3);
    vecs[15] = mk(0, 1, 1, 'h60,    1, 'h1060,  1, 1, 'h1010,  0,   1, 'h10,   1, 0, 'h500,  3, 0, 3);
    vecs[16] = mk(0, 1, 0, 0,       0, 0,       1, 1, 'h1020,  0,   1, 'h20,   1, 0, 'h500,  2, 0, 3);
    vecs[17] = mk(0, 1, 0, 0,       0, 0,       1, 1, 'h1030,  0,   1, 'h30,   1, 0, 'h500,  1, 0, 3);
    vecs[18] = mk(0, 1, 0, 0,       0, 0,       1, 1, 'h1040,  0,   1, 'h40,   1, 0, 'h500,  0, 0, 3);
    vecs[19] = mk(0, 1, 0, 0,       0, 0,       1, 0, 0,       0,   0, 'h40,   1, 0, 'h500,  0, 0, 3);
    vecs[20] = mk(0, 1, 1, 'h70,    0, 0,       0, 0, 0,       0,   0, 'h40,   1, 0, 'h500,  1, 0, 3);
    vecs[21] = mk(0, 1, 1, 'h80,    0, 0,       1, 0, 0,       0,   1, 'h70,   0, 0, 'h500,  1, 0, 3);
    vecs[22] = mk(0, 1, 1, 'h90,    0, 0,       0, 0, 0,       0,   0, 'h70,   0, 0, 'h500,  2, 0, 3);
    vecs[23] = mk(0, 1, 1, 'hA0,    0, 0,       1, 1, 'h900,   0,   1, 'h80,   1, 1, 'h900,  0, 0, 4);
    vecs[24] = mk(0, 1, 1, 'hB0,    0, 0,       0, 0, 0,       0,   0, 'h80,   1, 0, 'h900,  1, 0, 4);
    vecs[25] = mk(0, 0, 1, 'hC0,    0, 0,       1, 1, 'h777,   0,   0, 'h80,   1, 0, 'h900,  1, 0, 4);
    vecs[26] = mk(0, 1, 1, 'hD0,    0, 0,       1, 0, 0,       1,   1, 'hB0,   0, 0, 'h900,  0, 0, 4);
    vecs[27] = mk(0, 1, 1, 'hE0,    1, 'hF0,    0, 0, 0,       0,   0, 'hB0,   0, 0, 'h900,  1, 0, 4);
    vecs[28] = mk(0, 1, 1, 'hF0,    0, 0,       0, 0, 0,       1,   0, 'hB0,   0, 0, 'h900,  0, 0, 4);
    vecs[29] = mk(0, 1, 1, 'h100,   1, 'h200,   0, 0, 0,       0,   0, 'hB0,   0, 0, 'h900,  1, 0, 4);
    vecs[30] = mk(0, 1, 1, 'h104,   0, 0,       0, 0, 0,       0,   0, 'hB0,   0, 0, 'h900,  2, 0, 4);
    vecs[31] = mk(0, 1, 0, 0,       0, 0,       1, 0, 0,       1,   1, 'h100,  0, 1, 'h104,  0, 0, 5);
    vecs[32] = mk(0, 1, 1, 'h300,   0, 0,       0, 0, 0,       0,   0, 'h100,  0, 0, 'h104,  1, 0, 5);
    vecs[33] = mk(1, 1, 0, 0,       0, 0,       1, 1, 'h999,   0,   0, 0,      0, 0, 0,      0, 0, 0);

    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 34; i++) begin
      drive(vecs[i].rst, vecs[i].rdy, vecs[i].fetch, vecs[i].pc, vecs[i].pt,
            vecs[i].ptgt, vecs[i].rv, vecs[i].rt, vecs[i].rtgt, vecs[i].xf);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i),
            128'({we, wa, rtk, fl, rd, cnt, full, mc}),
            128'({vecs[i].we, vecs[i].wa, vecs[i].ert, vecs[i].fl, vecs[i].rd,
                  vecs[i].cnt, vecs[i].full, vecs[i].mc}));
      check($sformatf("vec%0d_narrow", i),
            128'({s_we, s_wa, s_rtk, s_fl, s_rd, s_cnt, s_full, s_mc}),
            128'({vecs[i].we, vecs[i].wa, vecs[i].ert, vecs[i].fl, vecs[i].rd,
                  vecs[i].cnt, vecs[i].full, vecs[i].mc[3:0]}));
    end

    // Repeated mispredicts: 16-bit counter counts on, 4-bit one pins at 0xF
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      drive(0, 1, 1, 'h1000, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      drive(0, 1, 0, 0, 0, 0, 1, 1, 'h2000, 0);
      @(posedge clk); #1;
      if (k == 14) begin
        check("mc_14", 128'({mc, 12'h0, s_mc}), 128'({16'd14, 12'h0, 4'd14}));
      end
      if (k == 15) begin
        check("mc_15_sat", 128'({mc, 12'h0, s_mc}), 128'({16'd15, 12'h0, 4'hF}));
      end
    end
    check("mc_20_sat", 128'({mc, 12'h0, s_mc, 3'b0, s_fl, 3'b0, fl, rd, s_cnt}),
          128'({16'd20, 12'h0, 4'hF, 3'b0, 1'b1, 3'b0, 1'b1, 32'h2000, 3'd0}));

    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("flush_pulse_end", 128'({fl, we, s_fl, s_we}), 128'(4'b0000));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
